// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg
// Shared definitions for the stream multiplexer / arbiter slice.
//   mode_e               : output selection mode (explicit select or round-robin)
//   NumChMin / NumChMax  : legal bounds on the channel count parameter
//   next_ptr()           : round-robin pointer advance that wraps at the channel
//                          count rather than at a power of two
package stream_mux_pkg;

  typedef enum logic {
    MODE_SELECT = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  localparam int NumChMin = 2;
  localparam int NumChMax = 32;

  // The pointer moves to the channel after the one just granted. It wraps at
  // num_ch so that non-power-of-two channel counts never point at a
  // nonexistent channel.
  function automatic int next_ptr(input int gnt, input int num_ch);
    return (gnt == num_ch - 1) ? 0 : gnt + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin arbiter. Starting at ptr, it scans upward
// through the request vector and wraps at NumCh. The first channel found
// requesting wins.
// Ports:
//   req      in   NumCh  per-channel request
//   ptr      in   SelW   highest-priority channel this cycle (always < NumCh)
//   gnt      out  SelW   index of the winning channel (0 when nothing requests)
//   gnt_vld  out  1      at least one channel is requesting
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int NumCh = 8,
  localparam int SelW  = $clog2(NumCh)
) (
  input  logic [NumCh-1:0] req,
  input  logic [SelW-1:0]  ptr,
  output logic [SelW-1:0]  gnt,
  output logic             gnt_vld
);

  logic [SelW-1:0] cand;

  // The candidate index is formed in int arithmetic and folded back below
  // NumCh. The narrowed SelW-bit value is therefore always a legal channel,
  // even when NumCh is not a power of two.
  always_comb begin
    int sum;
    gnt     = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    sum     = 0;
    for (int i = 0; i < NumCh; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NumCh) begin
        sum = sum - NumCh;
      end
      cand = sum[SelW-1:0];
      if (!gnt_vld && req[cand]) begin
        gnt     = cand;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// stream_mux_arb
// N-channel, W-bit stream multiplexer with a registered output stage.
// Each input channel has its own valid/ready handshake. The channel is picked
// either by an explicit select or by round-robin arbitration, and the output
// word carries the index of the channel that produced it.
// The block sustains one word per cycle with one cycle of latency.
// Ports:
//   clk_i    in   1            clock, rising edge
//   rst_i    in   1            synchronous active-low reset
//   mode_i   in   1            0 = select mode, 1 = round-robin mode
//   sel_i    in   SelW         channel index used in select mode
//   valid_i  in   NumCh        per-channel valid
//   data_i   in   NumCh*Width  packed channel data, channel k at [k*Width +: Width]
//   ready_o  out  NumCh        per-channel ready, at most one bit set
//   valid_o  out  1            output word valid
//   data_o   out  Width        output word
//   ch_o     out  SelW         source channel of data_o
//   ready_i  in   1            consumer ready
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter  int Width = 16,
  parameter  int NumCh = 8,
  localparam int SelW  = $clog2(NumCh)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   mode_i,
  input  logic [SelW-1:0]        sel_i,
  input  logic [NumCh-1:0]       valid_i,
  input  logic [NumCh*Width-1:0] data_i,
  output logic [NumCh-1:0]       ready_o,
  output logic                   valid_o,
  output logic [Width-1:0]       data_o,
  output logic [SelW-1:0]        ch_o,
  input  logic                   ready_i
);

  mode_e           mode;
  logic [SelW-1:0] ptr;
  logic [SelW-1:0] rr_gnt;
  logic            rr_gnt_vld;
  logic [SelW-1:0] gnt;
  logic            grant_vld;
  logic            sel_in_range;
  logic            load_en;
  logic            xfer;
  logic [Width-1:0] ch_data [NumCh];

  assign mode = mode_e'(mode_i);

  // Unpack the flat data bus so the granted word can be picked with a plain
  // array index.
  for (genvar k = 0; k < NumCh; k++) begin : g_unpack
    assign ch_data[k] = data_i[k*Width +: Width];
  end

  rr_arbiter #(
    .NumCh (NumCh)
  ) u_rr_arbiter (
    .req     (valid_i),
    .ptr     (ptr),
    .gnt     (rr_gnt),
    .gnt_vld (rr_gnt_vld)
  );

  // sel_i can encode indices beyond the last channel when NumCh is not a
  // power of two. Such values must never produce a grant.
  assign sel_in_range = (int'(sel_i) < NumCh);

  // Select mode uses sel_i directly. Round-robin mode takes the arbiter's
  // winner. Mode is sampled every cycle and keeps no state of its own.
  always_comb begin
    gnt       = '0;
    grant_vld = 1'b0;
    if (mode == MODE_SELECT) begin
      gnt       = sel_i;
      grant_vld = sel_in_range && valid_i[sel_i];
    end else begin
      gnt       = rr_gnt;
      grant_vld = rr_gnt_vld;
    end
  end

  // The output stage can take a word when it is empty, or when its current
  // word leaves on this same edge. This allows drain and fill without a bubble.
  assign load_en = !valid_o || ready_i;

  // A grant already implies valid_i[gnt], so a transfer happens exactly when
  // ready is offered to the granted channel. Holding ready low during reset
  // keeps producers from seeing a transfer that the reset would discard.
  assign xfer = load_en && grant_vld && rst_i;

  // Drive a one-hot ready back to the granted channel only.
  always_comb begin
    ready_o = '0;
    if (xfer) begin
      ready_o[gnt] = 1'b1;
    end
  end

  // Output register and round-robin pointer. The pointer also advances on
  // select-mode transfers, so a later switch to round-robin continues fairly
  // from the last channel served. Outputs depend only on registered state,
  // so ready_i has no combinational path to data_o or valid_o.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      ch_o    <= '0;
      ptr     <= '0;
    end else if (xfer) begin
      valid_o <= 1'b1;
      data_o  <= ch_data[gnt];
      ch_o    <= gnt;
      ptr     <= SelW'(next_ptr(int'(gnt), NumCh));
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule
